// File: rtl/serv_seq_pkg.sv
// Shared state encodings and run-length helpers for the serial fetch/execute sequencer.
// Bit positions in a run are counted over one 32-bit word.
package serv_seq_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned POS_BITS = 5;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StRfReq   = 3'd2,
        StRfWait  = 3'd3,
        StRun1    = 3'd4,
        StMemWait = 3'd5,
        StRun2    = 3'd6
    } seq_state_e;

    function automatic int unsigned beats_per_run(input int unsigned w);
        return XLEN / w;
    endfunction

    // True when a beat starting at bit pos and spanning w bits includes bit_idx.
    function automatic logic beat_covers(input logic [POS_BITS-1:0] pos,
                                         input int unsigned         bit_idx,
                                         input int unsigned         w);
        int unsigned lo;
        lo = 32'(pos);
        return (bit_idx >= lo) && (bit_idx < lo + w);
    endfunction

endpackage

// File: rtl/serv_beat_cnt.sv
// Bit-position counter for one serial run, with the beat strobes the PC/ALU datapath uses.
// Position restarts at 0 whenever no run is active, so every run begins on bit 0.
module serv_beat_cnt
    import serv_seq_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_cnt_en,
    output logic o_cnt0,
    output logic o_cnt1,
    output logic o_cnt2,
    output logic o_cnt12to31,
    output logic o_cnt_done
);

    localparam logic [POS_BITS-1:0] STEP      = POS_BITS'(W);
    localparam logic [POS_BITS-1:0] FINAL_POS = POS_BITS'((beats_per_run(W) - 1) * W);

    logic [POS_BITS-1:0] r_pos;

    // The 5-bit add wraps 31->0 (W=1) and 28->0 (W=4) on its own.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_pos <= '0;
        end else if (i_run) begin
            r_pos <= r_pos + STEP;
        end else begin
            r_pos <= '0;
        end
    end

    assign o_cnt_en    = i_run;
    assign o_cnt0      = i_run & beat_covers(r_pos, 0, W);
    assign o_cnt1      = i_run & beat_covers(r_pos, 1, W);
    assign o_cnt2      = i_run & beat_covers(r_pos, 2, W);
    assign o_cnt12to31 = i_run & (r_pos >= POS_BITS'(12));
    assign o_cnt_done  = i_run & (r_pos == FINAL_POS);

endmodule

// File: rtl/serv_fetch_seq.sv
// Fetch/decode/execute sequencer for a bit-serial core: fetch, operand read, one or two
// serial passes with an optional wait between them, then straight into the next fetch.
module serv_fetch_seq
    import serv_seq_pkg::*;
#(
    parameter int unsigned W                 = 1,
    parameter bit          RESET_PC_EN_FETCH = 1'b1
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_halt,
    output logic o_ibus_cyc,
    input  logic i_ibus_ack,
    output logic o_rf_rreq,
    input  logic i_rf_ready,
    input  logic i_two_stage,
    input  logic i_mem_ready,
    input  logic i_trap,
    output logic o_cnt_en,
    output logic o_pc_en,
    output logic o_cnt0,
    output logic o_cnt1,
    output logic o_cnt2,
    output logic o_cnt12to31,
    output logic o_cnt_done
);

    seq_state_e r_state;
    logic       r_armed;
    logic       r_two_stage;
    logic       r_ibus_cyc;
    logic       r_rf_rreq;
    logic       r_run;
    logic       r_pc_en;
    logic       w_cnt_done;

    serv_beat_cnt #(
        .W (W)
    ) u_beat_cnt (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_run       (r_run),
        .o_cnt_en    (o_cnt_en),
        .o_cnt0      (o_cnt0),
        .o_cnt1      (o_cnt1),
        .o_cnt2      (o_cnt2),
        .o_cnt12to31 (o_cnt12to31),
        .o_cnt_done  (w_cnt_done)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_armed     <= 1'b0;
            r_two_stage <= 1'b0;
            r_ibus_cyc  <= 1'b0;
            r_rf_rreq   <= 1'b0;
            r_run       <= 1'b0;
            r_pc_en     <= 1'b0;
        end else begin
            // Arming takes one cycle, so the first fetch lands on the second edge after reset.
            if (!r_armed) begin
                r_armed <= RESET_PC_EN_FETCH | i_halt;
            end
            unique case (r_state)
                StIdle: begin
                    if (r_armed && !i_halt) begin
                        r_state    <= StFetch;
                        r_ibus_cyc <= 1'b1;
                    end
                end
                StFetch: begin
                    if (i_ibus_ack) begin
                        r_state    <= StRfReq;
                        r_ibus_cyc <= 1'b0;
                        r_rf_rreq  <= 1'b1;
                    end
                end
                StRfReq: begin
                    r_state   <= StRfWait;
                    r_rf_rreq <= 1'b0;
                end
                StRfWait: begin
                    if (i_rf_ready) begin
                        r_two_stage <= i_two_stage;
                        r_state     <= i_two_stage ? StRun1 : StRun2;
                        r_run       <= 1'b1;
                        r_pc_en     <= ~i_two_stage;
                    end
                end
                StRun1: begin
                    if (w_cnt_done) begin
                        r_state <= r_two_stage ? StMemWait : StRun2;
                        r_run   <= ~r_two_stage;
                        r_pc_en <= ~r_two_stage;
                    end
                end
                StMemWait: begin
                    if (i_trap || i_mem_ready) begin
                        r_state <= StRun2;
                        r_run   <= 1'b1;
                        r_pc_en <= 1'b1;
                    end
                end
                StRun2: begin
                    if (w_cnt_done) begin
                        r_two_stage <= 1'b0;
                        r_run       <= 1'b0;
                        r_pc_en     <= 1'b0;
                        if (i_halt) begin
                            r_state <= StIdle;
                        end else begin
                            r_state    <= StFetch;
                            r_ibus_cyc <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_two_stage <= 1'b0;
                    r_ibus_cyc  <= 1'b0;
                    r_rf_rreq   <= 1'b0;
                    r_run       <= 1'b0;
                    r_pc_en     <= 1'b0;
                end
            endcase
        end
    end

    assign o_ibus_cyc = r_ibus_cyc;
    assign o_rf_rreq  = r_rf_rreq;
    assign o_pc_en    = r_pc_en;
    assign o_cnt_done = w_cnt_done;

endmodule

// File: tb/tb_serv_fetch_seq.sv
// Scoreboard bench for serv_fetch_seq: one W=1 and one W=4 instance, directed sequencing
// scenarios, expected beat strobes queued up front and checked by an independent monitor.
module tb_serv_fetch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v, halt_v, ack_v, rfr_v, two_v, memr_v, trap_v;
    logic [1:0] cyc_v, rreq_v, en_v, pc_v, c0_v, c1_v, c2_v, c12_v, done_v;

    int vectors     = 0;
    int miscompares = 0;

    // Beat record: {pc_en, cnt_done, cnt12to31, cnt2, cnt1, cnt0}
    logic [5:0] q0[$];
    logic [5:0] q1[$];

    serv_fetch_seq #(.W(1), .RESET_PC_EN_FETCH(1'b1)) u_dut_w1 (
        .clk(clk), .i_rst(rst_v[0]), .i_halt(halt_v[0]), .o_ibus_cyc(cyc_v[0]),
        .i_ibus_ack(ack_v[0]), .o_rf_rreq(rreq_v[0]), .i_rf_ready(rfr_v[0]),
        .i_two_stage(two_v[0]), .i_mem_ready(memr_v[0]), .i_trap(trap_v[0]),
        .o_cnt_en(en_v[0]), .o_pc_en(pc_v[0]), .o_cnt0(c0_v[0]), .o_cnt1(c1_v[0]),
        .o_cnt2(c2_v[0]), .o_cnt12to31(c12_v[0]), .o_cnt_done(done_v[0])
    );

    serv_fetch_seq #(.W(4), .RESET_PC_EN_FETCH(1'b1)) u_dut_w4 (
        .clk(clk), .i_rst(rst_v[1]), .i_halt(halt_v[1]), .o_ibus_cyc(cyc_v[1]),
        .i_ibus_ack(ack_v[1]), .o_rf_rreq(rreq_v[1]), .i_rf_ready(rfr_v[1]),
        .i_two_stage(two_v[1]), .i_mem_ready(memr_v[1]), .i_trap(trap_v[1]),
        .o_cnt_en(en_v[1]), .o_pc_en(pc_v[1]), .o_cnt0(c0_v[1]), .o_cnt1(c1_v[1]),
        .o_cnt2(c2_v[1]), .o_cnt12to31(c12_v[1]), .o_cnt_done(done_v[1])
    );

    function automatic logic [5:0] beat_vec(input int d);
        return {pc_v[d], done_v[d], c12_v[d], c2_v[d], c1_v[d], c0_v[d]};
    endfunction

    function automatic logic [8:0] outs(input int d);
        return {cyc_v[d], rreq_v[d], en_v[d], pc_v[d], c0_v[d], c1_v[d], c2_v[d], c12_v[d],
                done_v[d]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived W=1 strobes: bit K on beat K, upper field from beat 12, done on beat 31.
    task automatic push_w1(input int n, input logic pc);
        for (int b = 0; b < n; b++) begin
            q0.push_back({pc, b == 31, b >= 12, b == 2, b == 1, b == 0});
        end
    endtask

    // Hand-derived W=4 strobes: bits 0..2 on beat 0, upper field beats 3..7, done on beat 7.
    task automatic push_w4();
        for (int b = 0; b < 8; b++) begin
            q1.push_back({1'b1, b == 7, b >= 3, b == 0, b == 0, b == 0});
        end
    endtask

    // Starts in FETCH; ends on the first beat of the run.
    task automatic do_fetch(input int d, input logic two);
        ack_v[d] = 1'b1;
        tick();
        ack_v[d] = 1'b0;
        check("rf_rreq_pulse", rreq_v[d], 1);
        tick();
        check("rf_rreq_one_cycle", rreq_v[d], 0);
        rfr_v[d] = 1'b1;
        two_v[d] = two;
        tick();
        rfr_v[d] = 1'b0;
        two_v[d] = 1'b0;
        check("run_entry", en_v[d], 1);
    endtask

    task automatic wait_run(input int d, output int n);
        n = 0;
        while (en_v[d] === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    // Monitor: every beat the DUT presents is matched against the next queued expectation.
    always @(negedge clk) begin
        logic [5:0] exp_b;
        for (int d = 0; d < 2; d++) begin
            if (en_v[d] === 1'b1) begin
                vectors++;
                if (d == 0 && q0.size() > 0) begin
                    exp_b = q0.pop_front();
                end else if (d == 1 && q1.size() > 0) begin
                    exp_b = q1.pop_front();
                end else begin
                    miscompares++;
                    $display("FAIL beat_w%0d: unexpected beat, got %b, expected none (t=%0t)",
                             d, beat_vec(d), $time);
                    continue;
                end
                if (beat_vec(d) !== exp_b) begin
                    miscompares++;
                    $display("FAIL beat_w%0d: got %b, expected %b (t=%0t)",
                             d, beat_vec(d), exp_b, $time);
                end
            end else if (beat_vec(d) !== 6'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_strobes_w%0d: got %b, expected 000000 (t=%0t)",
                         d, beat_vec(d), $time);
            end
        end
    end

    initial begin
        int n;
        rst_v  = 2'b11;
        halt_v = 2'b00;
        ack_v  = 2'b00;
        rfr_v  = 2'b00;
        two_v  = 2'b00;
        memr_v = 2'b00;
        trap_v = 2'b00;
        repeat (2) tick();
        check("reset_outputs_w1", outs(0), 0);
        check("reset_outputs_w4", outs(1), 0);

        // Single-stage W=1: ack on third FETCH cycle, operands two cycles into RF_WAIT.
        push_w1(32, 1'b1);
        rst_v[0] = 1'b0;
        tick();
        check("no_fetch_first_edge", cyc_v[0], 0);
        tick();
        check("fetch_second_edge", cyc_v[0], 1);
        tick();
        tick();
        check("fetch_held", cyc_v[0], 1);
        ack_v[0] = 1'b1;
        tick();
        ack_v[0] = 1'b0;
        check("cyc_drops_after_ack", cyc_v[0], 0);
        check("rf_rreq_after_ack", rreq_v[0], 1);
        rfr_v[0] = 1'b1;
        tick();
        rfr_v[0] = 1'b0;
        check("early_ready_ignored", en_v[0], 0);
        check("rf_rreq_dropped", rreq_v[0], 0);
        tick();
        check("rf_wait_held", en_v[0], 0);
        rfr_v[0] = 1'b1;
        tick();
        rfr_v[0] = 1'b0;
        check("run2_entry", {en_v[0], pc_v[0]}, 2'b11);
        wait_run(0, n);
        check("run2_len_w1", n, 32);
        check("fetch_direct_after_run2", cyc_v[0], 1);

        // Two-stage with mem_ready after 5 MEM_WAIT cycles; trap pulsed outside MEM_WAIT.
        push_w1(32, 1'b0);
        push_w1(32, 1'b1);
        trap_v[0] = 1'b1;
        do_fetch(0, 1'b1);
        trap_v[0] = 1'b0;
        check("run1_no_pc_en", pc_v[0], 0);
        wait_run(0, n);
        check("run1_len", n, 32);
        repeat (4) tick();
        check("mem_wait_held", {en_v[0], cyc_v[0]}, 2'b00);
        memr_v[0] = 1'b1;
        tick();
        memr_v[0] = 1'b0;
        check("run2_after_mem_ready", {en_v[0], pc_v[0]}, 2'b11);
        wait_run(0, n);
        check("run2_len_after_mem", n, 32);
        check("fetch_after_two_stage", cyc_v[0], 1);

        // Two-stage with trap on the first MEM_WAIT cycle.
        push_w1(32, 1'b0);
        push_w1(32, 1'b1);
        do_fetch(0, 1'b1);
        wait_run(0, n);
        check("run1_len_trap", n, 32);
        trap_v[0] = 1'b1;
        tick();
        trap_v[0] = 1'b0;
        check("run2_after_trap", {en_v[0], pc_v[0]}, 2'b11);
        wait_run(0, n);
        check("run2_len_after_trap", n, 32);

        // Halt on the final beat, then release.
        push_w1(32, 1'b1);
        do_fetch(0, 1'b0);
        halt_v[0] = 1'b1;
        wait_run(0, n);
        check("run2_len_halt", n, 32);
        check("idle_after_halt", cyc_v[0], 0);
        tick();
        tick();
        check("idle_held", cyc_v[0], 0);
        halt_v[0] = 1'b0;
        tick();
        check("fetch_after_halt_fall", cyc_v[0], 1);

        // Reset at RUN2 beat 10, with ack and rf_ready held high while in reset.
        push_w1(10, 1'b1);
        do_fetch(0, 1'b0);
        repeat (10) tick();
        check("in_run_before_reset", en_v[0], 1);
        rst_v[0] = 1'b1;
        ack_v[0] = 1'b1;
        rfr_v[0] = 1'b1;
        #1;
        check("async_reset_mid_run", outs(0), 0);
        tick();
        check("reset_beats_ack_ready", outs(0), 0);
        rst_v[0] = 1'b0;
        ack_v[0] = 1'b0;
        rfr_v[0] = 1'b0;
        tick();
        check("no_fetch_first_edge_rerun", cyc_v[0], 0);
        tick();
        check("fetch_second_edge_rerun", cyc_v[0], 1);

        // W=4 single-stage run.
        push_w4();
        rst_v[1] = 1'b0;
        tick();
        tick();
        check("fetch_second_edge_w4", cyc_v[1], 1);
        do_fetch(1, 1'b0);
        wait_run(1, n);
        check("run2_len_w4", n, 8);
        check("fetch_direct_w4", cyc_v[1], 1);

        tick();
        check("w1_queue_drained", q0.size(), 0);
        check("w4_queue_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
